// File: rtl/scan_pkg.sv
// scan_pkg: shared types and sizes for the truth-table scanner.
//   state_t  - scanner FSM states (IDLE, APPLY, SAMPLE, DONE)
//   NUM_VEC  - number of input vectors in one scan (4 inputs -> 16)
//   IDX_W    - vector index width
//   CNT_W    - mismatch counter width (must hold 0..16)
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

endpackage

// File: rtl/scan_settle_timer.sv
// scan_settle_timer: settle-time down-counter for the scanner.
// Parameters:
//   SETTLE  - cycles a vector is held before it is sampled (1..15)
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset
//   load    - reload the counter for a fresh APPLY phase
//   en      - count down (held high while in APPLY)
//   expired - last APPLY cycle for this vector
module scan_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  // Loading SETTLE-1 gives exactly SETTLE APPLY cycles: expired is seen
  // in the SETTLE-th cycle and the FSM leaves APPLY on that edge.
  localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt_q <= '0;
    else if (load)                cnt_q <= LOAD_VAL;
    else if (en && cnt_q != '0)   cnt_q <= cnt_q - 4'd1;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks all 16 vectors of a 4-input combinational
// function, samples its output, builds the truth table and compares it
// with an expected mask.
// Optional feature: define SCAN_ERRCNT_EN to add the err_count output
// (number of vectors whose sample differs from the mask).
// Parameters:
//   SETTLE    - cycles each vector is held before sampling (1..15)
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   start     - scan request, only looked at in IDLE
//   mask      - expected truth table, captured at start acceptance
//   s_in      - output of the function under scan
//   vec       - applied vector {x,y,w,z}; zero outside APPLY/SAMPLE
//   busy      - scan in progress (APPLY, SAMPLE, DONE)
//   done      - one-cycle completion pulse
//   table_q   - captured truth table, bit i = sample for vector i
//   match     - table_q equals captured mask; valid from done
//   err_count - mismatch count 0..16 (SCAN_ERRCNT_EN only)
module truth_table_scanner
  import scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_VEC-1:0]   mask,
  input  logic                 s_in,
  output logic [IDX_W-1:0]     vec,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_VEC-1:0]   table_q,
  output logic                 match
`ifdef SCAN_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]     err_count
`endif
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_VEC-1:0] mask_q, mask_d;
  logic [NUM_VEC-1:0] tbl_q, tbl_d;
  logic               match_q, match_d;
  logic               tmr_load, tmr_en, tmr_expired;

  scan_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    tbl_d    = tbl_q;
    match_d  = match_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = mask;
          idx_d    = '0;
          tbl_d    = '0;
          match_d  = 1'b0;
          tmr_load = 1'b1;
          state_d  = APPLY;
        end
      end
      APPLY: begin
        tmr_en = 1'b1;
        if (tmr_expired) state_d = SAMPLE;
      end
      SAMPLE: begin
        tbl_d[idx_q] = s_in;
        if (idx_q == IDX_W'(NUM_VEC - 1)) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = APPLY;
        end
      end
      DONE: begin
        match_d = (tbl_q == mask_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      tbl_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      tbl_q   <= tbl_d;
      match_q <= match_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them
  // without waiting for a clock.
  assign vec     = (state_q == APPLY || state_q == SAMPLE) ? idx_q : '0;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign table_q = tbl_q;
  // The table is complete on entry to DONE, so match is driven from the
  // live compare during the done pulse and from the register afterwards.
  assign match   = (state_q == DONE) ? (tbl_q == mask_q) : match_q;

`ifdef SCAN_ERRCNT_EN
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= '0;
    else if (state_q == IDLE && start)
      err_q <= '0;
    else if (state_q == SAMPLE && (s_in != mask_q[idx_q]))
      err_q <= err_q + 1'b1;
  end

  assign err_count = err_q;
`else
  // No mismatch counter in this build.
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: directed self-checking bench for
// truth_table_scanner. Instance u_s1 runs with SETTLE=1, u_s3 with
// SETTLE=3. The function under scan is the SoP over minterms
// 1,3,4,6,9,12,13 (truth table 16'h325A), or constant 0 when tie0 is set.
// err_count is checked only when SCAN_ERRCNT_EN is defined.
module tb_truth_table_scanner;

  logic        clk, reset;
  logic        start1, start3, tie0;
  logic [15:0] mask;
  logic [3:0]  vec1, vec3;
  logic        busy1, busy3, done1, done3, match1, match3;
  logic [15:0] tbl1, tbl3;
  logic        s_in1, s_in3;
`ifdef SCAN_ERRCNT_EN
  logic [4:0]  err1, err3;
`endif

  int total = 0;
  int bad   = 0;
  int nd1   = 0;

  function automatic logic sop(input logic [3:0] v);
    return (v == 4'd1) || (v == 4'd3) || (v == 4'd4) || (v == 4'd6) ||
           (v == 4'd9) || (v == 4'd12) || (v == 4'd13);
  endfunction

  assign s_in1 = tie0 ? 1'b0 : sop(vec1);
  assign s_in3 = tie0 ? 1'b0 : sop(vec3);

  truth_table_scanner #(.SETTLE(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start1), .mask(mask), .s_in(s_in1),
    .vec(vec1), .busy(busy1), .done(done1), .table_q(tbl1), .match(match1)
`ifdef SCAN_ERRCNT_EN
    , .err_count(err1)
`endif
  );

  truth_table_scanner #(.SETTLE(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start3), .mask(mask), .s_in(s_in3),
    .vec(vec3), .busy(busy3), .done(done3), .table_q(tbl3), .match(match3)
`ifdef SCAN_ERRCNT_EN
    , .err_count(err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done1) nd1++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Runs one scan on u_s1. Start is driven in cycle 0; mask is scrambled
  // right after acceptance. Returns the cycle done was seen (-1 if never)
  // and match during that cycle; returns in the cycle after done.
  task automatic scan1(input logic [15:0] m, input bit restart,
                       output int dcyc, output logic dmatch);
    mask   = m;
    start1 = 1'b1;
    dcyc   = -1;
    dmatch = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0;
    mask   = ~m;
    chk("busy_c1", busy1, 1);
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (restart) start1 = (cyc == 10 || cyc == 33);
      if (done1) begin
        dcyc   = cyc;
        dmatch = match1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  int   dc, nd0;
  logic dm;
  logic [3:0] v_c1, v_c4, v_c5, v_c8, v_c9;

  initial begin
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; tie0 = 1'b0; mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  busy1,  0);
    chk("rst_done",  done1,  0);
    chk("rst_vec",   vec1,   0);
    chk("rst_table", tbl1,   0);
    chk("rst_match", match1, 0);
`ifdef SCAN_ERRCNT_EN
    chk("rst_err",   err1,   0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // exact match
    scan1(16'h325A, 0, dc, dm);
    chk("A_done_cyc", dc, 33);
    chk("A_match_done", dm, 1);
    chk("A_table", tbl1, 16'h325A);
`ifdef SCAN_ERRCNT_EN
    chk("A_err", err1, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("A_hold_table", tbl1, 16'h325A);
    chk("A_hold_match", match1, 1);
    chk("A_idle_busy", busy1, 0);
    chk("A_idle_vec", vec1, 0);

    // one-bit mismatch
    scan1(16'h325B, 0, dc, dm);
    chk("B_done_cyc", dc, 33);
    chk("B_match_done", dm, 0);
    chk("B_table", tbl1, 16'h325A);
    chk("B_match_hold", match1, 0);
`ifdef SCAN_ERRCNT_EN
    chk("B_err", err1, 1);
`endif

    // s_in stuck at 0 against all-ones mask
    tie0 = 1'b1;
    scan1(16'hFFFF, 0, dc, dm);
    chk("C_done_cyc", dc, 33);
    chk("C_table", tbl1, 16'h0000);
    chk("C_match", dm, 0);
`ifdef SCAN_ERRCNT_EN
    chk("C_err", err1, 16);
`endif
    tie0 = 1'b0;

    // start re-asserted during the scan and in the DONE cycle
    nd0 = nd1;
    scan1(16'h325A, 1, dc, dm);
    chk("D_done_cyc", dc, 33);
    repeat (3) @(posedge clk);
    #1;
    chk("D_done_count", nd1 - nd0, 1);
    chk("D_no_restart", busy1, 0);
    chk("D_match", match1, 1);

    // reset in cycle 12 of a scan
    mask = 16'h325A; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("E_busy_pre", busy1, 1);
    nd0 = nd1;
    reset = 1'b1;
    #1;
    chk("E_rst_busy",  busy1,  0);
    chk("E_rst_table", tbl1,   0);
    chk("E_rst_vec",   vec1,   0);
    chk("E_rst_match", match1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("E_no_done", nd1 - nd0, 0);
    chk("E_idle", busy1, 0);
    scan1(16'h325A, 0, dc, dm);
    chk("E_done_cyc", dc, 33);
    chk("E_table", tbl1, 16'h325A);
    chk("E_match", dm, 1);

    // SETTLE=3: four cycles per vector
    dc = -1;
    mask = 16'h325A; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (cyc == 1) v_c1 = vec3;
      if (cyc == 4) v_c4 = vec3;
      if (cyc == 5) v_c5 = vec3;
      if (cyc == 8) v_c8 = vec3;
      if (cyc == 9) v_c9 = vec3;
      if (done3) begin
        dc = cyc;
        dm = match3;
        break;
      end
      @(posedge clk); #1;
    end
    chk("F_vec_c1", v_c1, 0);
    chk("F_vec_c4", v_c4, 0);
    chk("F_vec_c5", v_c5, 1);
    chk("F_vec_c8", v_c8, 1);
    chk("F_vec_c9", v_c9, 2);
    chk("F_done_cyc", dc, 65);
    chk("F_match", dm, 1);
    chk("F_table", tbl3, 16'h325A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
- REQ-001: Parameter SETTLE, default 1, number of cycles each input vector is held before sampling; legal range 1..15.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: start  input  1  scan request; sampled only in IDLE.
- REQ-005: mask  input  16  expected truth table; bit i is the expected output for vector i; captured when start is accepted.
- REQ-006: s_in  input  1  output of the combinational function under scan.
- REQ-007: vec  output  4  applied vector; vec[3]=x, vec[2]=y, vec[1]=w, vec[0]=z.
- REQ-008: busy  output  1  high from the cycle after start acceptance through the DONE cycle.
- REQ-009: done  output  1  single-cycle pulse when a scan completes.
- REQ-010: table_q  output  16  captured truth table; bit i = s_in sampled for vector i.
- REQ-011: match  output  1  high when table_q equals the captured mask; valid from done.

Function
- REQ-012: States SHALL be IDLE, APPLY, SAMPLE and DONE, with the transitions in REQ-013 to REQ-016.
- REQ-013: IDLE with start=1 SHALL capture mask into mask_r, clear idx, table_q and match, and go to APPLY; IDLE with start=0 SHALL stay in IDLE.
- REQ-014: APPLY SHALL drive vec=idx for SETTLE cycles and then go to SAMPLE.
- REQ-015: SAMPLE SHALL hold vec=idx and write table_q[idx]<=s_in in the same cycle; if idx=15 it SHALL go to DONE, otherwise it SHALL do idx<=idx+1 and go to APPLY.
- REQ-016: DONE SHALL assert done=1 and match=(table_q==mask_r) for one cycle and then go to IDLE.
- REQ-017: With start accepted in cycle 0, done SHALL be high in cycle 16*(SETTLE+1)+1.
- REQ-018: vec SHALL be 4'b0000 in IDLE and DONE.
- REQ-019: idx SHALL be 4 bits and SHALL never wrap past 15 within one scan.
- REQ-020: start while busy, including the DONE cycle, SHALL be ignored; a new start is accepted on the first IDLE cycle.
- REQ-021: mask changes after acceptance SHALL NOT affect the running scan.
- REQ-022: table_q and match SHALL hold their values from DONE until the next accepted start.

Reset
- REQ-023: reset=1 SHALL force state=IDLE, vec=0, busy=0, done=0, table_q=0, match=0, idx=0 and mask_r=0 immediately, independent of clk.
- REQ-024: Reset during a scan SHALL abort it with no done pulse; the next start after reset release SHALL run a full scan.

Configuration
- REQ-025: With SCAN_ERRCNT_EN defined, the block SHALL add output err_count[4:0], cleared at start acceptance and incremented in each SAMPLE where s_in != mask_r[idx].
- REQ-026: With SCAN_ERRCNT_EN defined, err_count SHALL range 0..16, hold after DONE, and reset to 0.
- REQ-027: Without SCAN_ERRCNT_EN, the err_count port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-028: Package scan_pkg SHALL hold the state typedef (IDLE, APPLY, SAMPLE, DONE), NUM_VEC=16, IDX_W=4 and CNT_W=5.
- REQ-029: Sub-module scan_settle_timer SHALL implement the SETTLE down-counter (inputs load and en, output expired); all other logic SHALL be inline.

Verification
- REQ-030: SoP function over minterms 1,3,4,6,9,12,13 on s_in, mask=16'h325A, SETTLE=1 -> done at cycle 33, table_q=16'h325A, match=1, err_count=0.
- REQ-031: Same function, mask=16'h325B -> table_q=16'h325A, match=0, err_count=1.
- REQ-032: s_in tied to 0, mask=16'hFFFF -> table_q=16'h0000, match=0, err_count=16.
- REQ-033: start re-asserted in cycles 10 and 33 of a scan -> exactly one done (cycle 33); the next scan starts only from a start in IDLE.
- REQ-034: reset pulsed in cycle 12 of a scan -> busy=0, table_q=0, no done; a following scan completes with correct results.
- REQ-035: SETTLE=3 -> each vec value held 4 cycles, done at cycle 65.
